alpharetz_wb_stage: RTL and testbench



---
 rtl/alpharetz_wb_stage.sv | 127 ++++++++++++
 tb/tb_alpharetz_wb_stage.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alpharetz_wb_stage.sv
// Writeback stage: merges the unbuffered ALU result channel and a small buffered
// load-return channel onto the single register-file write port, with a bypass copy.
module alpharetz_wb_stage #(
    parameter int CPU_DATA_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int LD_FIFO_DEPTH  = 2
) (
    input  logic                              clk,
    input  logic                              async_rst_n,
    input  logic                              clk_en,
    input  logic                              sys_en,
    input  logic                              alu_valid,
    output logic                              alu_ready,
    input  logic [REG_ADDR_WIDTH-1:0]         alu_rd,
    input  logic [CPU_DATA_WIDTH-1:0]         alu_data,
    input  logic                              ld_valid,
    output logic                              ld_ready,
    input  logic [REG_ADDR_WIDTH-1:0]         ld_rd,
    input  logic [CPU_DATA_WIDTH-1:0]         ld_data,
    output logic                              wr_en,
    output logic [REG_ADDR_WIDTH-1:0]         wr_addr,
    output logic [CPU_DATA_WIDTH-1:0]         wr_data,
    output logic                              byp_valid,
    output logic [REG_ADDR_WIDTH-1:0]         byp_addr,
    output logic [CPU_DATA_WIDTH-1:0]         byp_data,
    output logic [$clog2(LD_FIFO_DEPTH):0]    ld_fifo_count
);
    localparam int PTR_W = $clog2(LD_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(LD_FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    typedef enum logic {
        GRANT_LOAD = 1'b0,
        GRANT_ALU  = 1'b1
    } grant_e;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [CPU_DATA_WIDTH-1:0] data;
    } result_t;

    result_t          fifo_mem [LD_FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    grant_e           last_grant;

    logic    advance;
    logic    fifo_full;
    logic    fifo_nonempty;
    logic    load_owed;
    logic    ld_grant;
    logic    alu_fire;
    logic    ld_push;
    logic    any_grant;
    result_t sel;

    // A buffered load is owed the port when the buffer is full or the ALU won last time.
    always_comb begin
        advance       = clk_en & sys_en;
        fifo_full     = (count == FULL_COUNT);
        fifo_nonempty = (count != '0);
        load_owed     = fifo_nonempty & (fifo_full | (last_grant == GRANT_ALU));
        ld_ready      = advance & ~fifo_full;
        alu_ready     = advance & ~load_owed;
        ld_grant      = advance & fifo_nonempty & (load_owed | ~alu_valid);
        alu_fire      = alu_valid & alu_ready & ~ld_grant;
        ld_push       = ld_valid & ld_ready;
        any_grant     = ld_grant | alu_fire;
        if (ld_grant) begin
            sel = fifo_mem[rd_ptr];
        end else begin
            sel.rd   = alu_rd;
            sel.data = alu_data;
        end
    end

    // NOTE: buffer storage carries no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (ld_push) begin
            fifo_mem[wr_ptr] <= '{rd: ld_rd, data: ld_data};
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            last_grant <= GRANT_LOAD;
        end else if (advance) begin
            // Results for r0 complete their handshake but never reach the register file.
            wr_en <= any_grant & (sel.rd != '0);
            if (any_grant) begin
                wr_addr <= sel.rd;
                wr_data <= sel.data;
            end
            if (ld_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (ld_grant) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({ld_push, ld_grant})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (ld_grant) begin
                last_grant <= GRANT_LOAD;
            end else if (alu_fire) begin
                last_grant <= GRANT_ALU;
            end
        end
    end

    assign byp_valid     = wr_en;
    assign byp_addr      = wr_addr;
    assign byp_data      = wr_data;
    assign ld_fifo_count = count;

endmodule

// File: tb/tb_alpharetz_wb_stage.sv
// Bench for alpharetz_wb_stage: directed scenarios plus random traffic, checked by a
// queue-based reference model feeding a scoreboard drained by an independent write monitor.
module tb_alpharetz_wb_stage;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int D  = 2;
    localparam int CW = $clog2(D) + 1;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } item_t;

    logic          clk;
    logic          async_rst_n;
    logic          clk_en;
    logic          sys_en;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_rd;
    logic [DW-1:0] ld_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          byp_valid;
    logic [AW-1:0] byp_addr;
    logic [DW-1:0] byp_data;
    logic [CW-1:0] ld_fifo_count;

    alpharetz_wb_stage #(
        .CPU_DATA_WIDTH(DW),
        .REG_ADDR_WIDTH(AW),
        .LD_FIFO_DEPTH (D)
    ) dut (
        .clk          (clk),
        .async_rst_n  (async_rst_n),
        .clk_en       (clk_en),
        .sys_en       (sys_en),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_rd        (ld_rd),
        .ld_data      (ld_data),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .byp_valid    (byp_valid),
        .byp_addr     (byp_addr),
        .byp_data     (byp_data),
        .ld_fifo_count(ld_fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    tests;
    int    fails;
    item_t fifo_q[$];     // reference load buffer
    item_t exp_q[$];      // writes the register file must see, in order
    bit    last_was_alu;
    bit    a_v;
    bit    l_v;
    item_t a_item;
    item_t l_item;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic item_t mk(input logic [AW-1:0] rd, input logic [DW-1:0] data);
        item_t it;
        it.rd   = rd;
        it.data = data;
        return it;
    endfunction

    // Decides what the upcoming edge does from the current offers and model state.
    task automatic model_cycle(output bit alu_took, output bit ld_took);
        bit    adv;
        bit    has_load;
        bit    full;
        bit    load_turn;
        bit    exp_alu_ready;
        bit    exp_ld_ready;
        item_t it;
        adv           = clk_en && sys_en;
        has_load      = fifo_q.size() != 0;
        full          = fifo_q.size() == D;
        load_turn     = has_load && (full || last_was_alu);
        exp_ld_ready  = adv && !full;
        exp_alu_ready = adv && !load_turn;
        check("alu_ready", alu_ready, exp_alu_ready);
        check("ld_ready", ld_ready, exp_ld_ready);
        check("ld_fifo_count", ld_fifo_count, fifo_q.size());
        alu_took = 1'b0;
        ld_took  = ld_valid && exp_ld_ready;
        if (adv && has_load && (load_turn || !alu_valid)) begin
            it = fifo_q.pop_front();
            last_was_alu = 1'b0;
            if (it.rd != 0) exp_q.push_back(it);
        end else if (alu_valid && exp_alu_ready) begin
            alu_took     = 1'b1;
            last_was_alu = 1'b1;
            if (alu_rd != 0) exp_q.push_back(mk(alu_rd, alu_data));
        end
        if (ld_took) fifo_q.push_back(mk(ld_rd, ld_data));
    endtask

    task automatic tick(input bit ce, input bit se);
        bit at;
        bit lt;
        @(posedge clk);
        #1;
        clk_en    = ce;
        sys_en    = se;
        alu_valid = a_v;
        alu_rd    = a_item.rd;
        alu_data  = a_item.data;
        ld_valid  = l_v;
        ld_rd     = l_item.rd;
        ld_data   = l_item.data;
        #1;
        model_cycle(at, lt);
        if (at) a_v = 1'b0;
        if (lt) l_v = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 20 && (a_v || l_v || fifo_q.size() != 0); n++) tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        check({tag, "_fifo_empty"}, ld_fifo_count, 0);
        check({tag, "_writes_pending"}, exp_q.size(), 0);
    endtask

    // Scoreboard side: a write commits when wr_en is high across an enabled edge.
    initial begin : monitor
        item_t e;
        forever begin
            @(negedge clk);
            if (async_rst_n && clk_en && sys_en && wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got r%0d=0x%0h, expected no write", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", wr_addr, e.rd);
                    check("wr_data", wr_data, e.data);
                    check("byp_valid", byp_valid, 1);
                    check("byp_addr", byp_addr, e.rd);
                    check("byp_data", byp_data, e.data);
                end
            end
        end
    end

    initial begin : stimulus
        bit full_seen;
        tests = 0;
        fails = 0;
        last_was_alu = 1'b0;
        a_v = 1'b0;
        l_v = 1'b0;
        a_item = '0;
        l_item = '0;
        clk_en = 1'b0;
        sys_en = 1'b0;
        alu_valid = 1'b0;
        alu_rd = '0;
        alu_data = '0;
        ld_valid = 1'b0;
        ld_rd = '0;
        ld_data = '0;
        async_rst_n = 1'b1;
        #1 async_rst_n = 1'b0;
        #2;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_count", ld_fifo_count, 0);
        check("rst_byp_valid", byp_valid, 0);
        #9 async_rst_n = 1'b1;

        // Single ALU result: visible the cycle after acceptance, gone the cycle after.
        a_v = 1'b1;
        a_item = mk(5'd3, 32'hDEADBEEF);
        tick(1'b1, 1'b1);
        check("t1_alu_ready", alu_ready, 1);
        tick(1'b1, 1'b1);
        check("t1_wr_en", wr_en, 1);
        check("t1_wr_addr", wr_addr, 3);
        check("t1_wr_data", wr_data, 32'hDEADBEEF);
        check("t1_byp_data", byp_data, 32'hDEADBEEF);
        tick(1'b1, 1'b1);
        check("t1_wr_en_clear", wr_en, 0);

        // Back-to-back loads, no ALU: first write two edges after enqueue, in order.
        l_v = 1'b1;
        l_item = mk(5'd1, 32'h11);
        tick(1'b1, 1'b1);
        check("t2_ld_ready", ld_ready, 1);
        l_v = 1'b1;
        l_item = mk(5'd2, 32'h22);
        tick(1'b1, 1'b1);
        check("t2_wr_en_n1", wr_en, 0);
        check("t2_count_n1", ld_fifo_count, 1);
        l_v = 1'b1;
        l_item = mk(5'd4, 32'h44);
        tick(1'b1, 1'b1);
        check("t2_wr_en_n2", wr_en, 1);
        check("t2_wr_addr_n2", wr_addr, 1);
        drain("t2");

        // Both sources busy every cycle: alternation, full buffer wins.
        full_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!a_v) begin
                a_v = 1'b1;
                a_item = mk(AW'($urandom_range(1, 31)), $urandom);
            end
            if (!l_v) begin
                l_v = 1'b1;
                l_item = mk(AW'($urandom_range(1, 31)), $urandom);
            end
            tick(1'b1, 1'b1);
            if (ld_fifo_count == CW'(D) && ld_ready == 1'b0) full_seen = 1'b1;
        end
        check("t3_full_seen", full_seen, 1);
        drain("t3");

        // r0 results complete their handshakes but never write.
        a_v = 1'b1;
        a_item = mk(5'd7, 32'h70);
        tick(1'b1, 1'b1);
        a_v = 1'b1;
        a_item = mk(5'd0, 32'hBAD0);
        tick(1'b1, 1'b1);
        check("t4_alu_r0_ready", alu_ready, 1);
        l_v = 1'b1;
        l_item = mk(5'd0, 32'hBAD1);
        tick(1'b1, 1'b1);
        check("t4_alu_r0_no_write", wr_en, 0);
        l_v = 1'b1;
        l_item = mk(5'd9, 32'h99);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        check("t4_ld_r0_no_write", wr_en, 0);
        check("t4_ld_r0_popped", ld_fifo_count, 1);
        drain("t4");

        // Disabled cycles hold the pending write and refuse new traffic.
        a_v = 1'b1;
        a_item = mk(5'd5, 32'h55);
        tick(1'b1, 1'b1);
        a_v = 1'b1;
        a_item = mk(5'd6, 32'h66);
        l_v = 1'b1;
        l_item = mk(5'd8, 32'h88);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0);
            check("t5_hold_wr_en", wr_en, 1);
            check("t5_hold_wr_addr", wr_addr, 5);
            check("t5_hold_wr_data", wr_data, 32'h55);
            check("t5_alu_ready_off", alu_ready, 0);
            check("t5_ld_ready_off", ld_ready, 0);
        end
        drain("t5");

        // Reset with a full load buffer discards everything in flight.
        for (int i = 0; i < 20 && fifo_q.size() != D; i++) begin
            if (!a_v) begin
                a_v = 1'b1;
                a_item = mk(AW'($urandom_range(1, 31)), $urandom);
            end
            if (!l_v) begin
                l_v = 1'b1;
                l_item = mk(AW'($urandom_range(1, 31)), $urandom);
            end
            tick(1'b1, 1'b1);
        end
        @(posedge clk);
        #1;
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        a_v = 1'b0;
        l_v = 1'b0;
        check("t6_count_before", ld_fifo_count, D);
        #1 async_rst_n = 1'b0;
        #1;
        check("t6_wr_en_rst", wr_en, 0);
        check("t6_count_rst", ld_fifo_count, 0);
        fifo_q.delete();
        exp_q.delete();
        last_was_alu = 1'b0;
        async_rst_n = 1'b1;
        #1;
        begin
            bit at;
            bit lt;
            model_cycle(at, lt);
        end
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
        check("t6_no_stale", wr_en, 0);

        // Random traffic with random enables and occasional r0 destinations.
        for (int i = 0; i < 300; i++) begin
            if (!a_v && $urandom_range(0, 9) < 6) begin
                a_v = 1'b1;
                a_item = mk(AW'($urandom_range(0, 31)), $urandom);
            end
            if (!l_v && $urandom_range(0, 9) < 6) begin
                l_v = 1'b1;
                l_item = mk(AW'($urandom_range(0, 31)), $urandom);
            end
            tick($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 85);
        end
        drain("rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
